instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter IMEM_DEPTH, default 32, number of 32-bit words in instruction memory (word-indexed addresses).
REQ-002 Parameter RESET_PC, default 32'h0, word address fetched first after reset.
REQ-003 Parameter FIFO_DEPTH, default 2, entries in the fetch buffer.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  start/continue fetching; 0 pauses new fetches without flushing the buffer.
REQ-007 imem_addr  output  32  word address presented to instruction memory.
REQ-008 imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-009 redirect_valid  input  1  branch/jump redirect request.
REQ-010 redirect_pc  input  32  new word address for the redirect.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr_ready  input  1  decode accepts the head instruction.
REQ-013 instr  output  32  head instruction word.
REQ-014 instr_pc  output  32  word address of head instruction.
REQ-015 halted  output  1  fetch stopped because pc >= IMEM_DEPTH.

Function
REQ-016 The unit SHALL hold a 32-bit pc and a state machine with states IDLE, FETCH, HALT.
REQ-017 imem_addr SHALL equal pc at all times (combinational from the register).
REQ-018 IDLE -> FETCH when en=1; FETCH -> IDLE when en=0; FETCH -> HALT when pc >= IMEM_DEPTH; HALT exits only via redirect or reset.
REQ-019 In FETCH with pc < IMEM_DEPTH, a push SHALL occur when the buffer is not full or a pop occurs in the same cycle: {pc, imem_data} is written and pc <= pc + 1.
REQ-020 Latency: an instruction fetched at edge N SHALL appear with instr_valid=1 in the cycle after edge N (one cycle address-to-valid).
REQ-021 instr_valid SHALL be 1 exactly when the buffer is non-empty; instr/instr_pc SHALL be the head entry, and 0 when empty.
REQ-022 A pop SHALL occur when instr_valid && instr_ready; head data SHALL remain stable while instr_valid && !instr_ready.
REQ-023 Full buffer with simultaneous pop and push SHALL keep occupancy constant and preserve order.
REQ-024 Redirect_valid at an edge SHALL flush the buffer, set pc <= redirect_pc, suppress that cycle's push and pop, and take priority over en and HALT.
REQ-025 After a redirect, next state SHALL be HALT if redirect_pc >= IMEM_DEPTH, else FETCH if en=1, else IDLE.
REQ-026 halted SHALL be 1 exactly in HALT; the buffer SHALL continue to drain in HALT.
REQ-027 pc arithmetic SHALL be 32-bit unsigned; increment at 32'hFFFFFFFF is unreachable because HALT is entered first.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, buffer empty, instr_valid=0, instr=0, instr_pc=0, halted=0, imem_addr=RESET_PC.
REQ-029 Assertion of rst_n mid-operation SHALL discard buffered instructions; no partial entry survives.
REQ-030 Outputs SHALL have no X after reset regardless of imem_data.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, default IMEM_DEPTH, RESET_PC, and the buffer entry type {pc[31:0], instr[31:0]}.
REQ-032 The buffer SHALL be a sub-module fetch_fifo (synchronous push/pop, flush, full/empty flags, async active-low reset).

Verification
REQ-033 Program words 0..31 = 32'h1000_0000+i, en=1, instr_ready=1 -> instr_pc 0..31 in order, one per cycle, first valid one cycle after en, then halted=1.
REQ-034 instr_ready=0 for 5 cycles after start -> buffer holds pc 0,1, imem_addr stays 2, instr=32'h1000_0000 stable; release -> 0,1,2... no loss or duplication.
REQ-035 Redirect_valid with redirect_pc=20 while buffer holds pc 3,4 -> entries 3,4 never accepted; next instr_pc=20 one cycle after redirect edge.
REQ-036 Redirect to pc=40 -> halted=1 next cycle, instr_valid=0, imem_addr=40; subsequent redirect to 5 resumes from pc 5.
REQ-037 rst_n pulsed low mid-stream with buffer full -> instr_valid=0 and imem_addr=RESET_PC immediately, restart from pc 0 after en.
REQ-038 en toggled 0 for 3 cycles mid-stream -> pc frozen, buffer drains, resumes at next sequential pc with no gaps.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam int          DEFAULT_IMEM_DEPTH = 32;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order fetch buffer: synchronous push/pop, flush, full/empty flags.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        do_pop   = pop && !empty && !flush;
        // A full buffer still accepts a write when the head leaves on the same edge.
        do_push  = push && (!full || do_pop) && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        rd_entry = empty ? '0 : mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the read port is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: walks pc through instruction memory into a
// small buffer, with redirect, pause and halt-at-end-of-memory handling.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted
);

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pc_in_range, do_fetch, fifo_push, fifo_pop;
    logic         fifo_empty, fifo_full;
    fetch_entry_t wr_entry, head;

    always_comb begin
        pc_in_range = (pc_q < DEPTH_W);
        // IDLE with en=1 fetches on the same edge that moves it into FETCH,
        // giving one cycle from enable to the first valid instruction.
        do_fetch    = en && (state_q != ST_HALT) && pc_in_range;
        fifo_pop    = !fifo_empty && instr_ready && !redirect_valid;
        fifo_push   = do_fetch && (!fifo_full || fifo_pop) && !redirect_valid;
        wr_entry    = '{pc: pc_q, instr: imem_data};

        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (redirect_pc >= DEPTH_W) state_d = ST_HALT;
            else if (en)                state_d = ST_FETCH;
            else                        state_d = ST_IDLE;
        end else begin
            if (fifo_push) pc_d = pc_q + 32'd1;
            case (state_q)
                ST_IDLE: begin
                    if (en) state_d = pc_in_range ? ST_FETCH : ST_HALT;
                end
                ST_FETCH: begin
                    if (!pc_in_range) state_d = ST_HALT;
                    else if (!en)     state_d = ST_IDLE;
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign imem_addr   = pc_q;
    assign instr_valid = !fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational instruction memory.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    // Program word i is 0x1000_0000 + i; out-of-range reads return junk.
    assign imem_data = (imem_addr < 32'd32) ? (32'h1000_0000 + imem_addr) : 32'hDEAD_BEEF;

    instr_fetch_unit #(.IMEM_DEPTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        check_eq({tag, ".pc"}, instr_pc, pc);
        check_eq({tag, ".instr"}, instr, 32'h1000_0000 + pc);
    endtask

    task automatic check_empty(input string tag, input logic [31:0] addr);
        check_eq({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
        check_eq({tag, ".imem_addr"}, imem_addr, addr);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        #3;
        check_eq("rst.valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst.instr", instr, 32'd0);
        check_eq("rst.instr_pc", instr_pc, 32'd0);
        check_eq("rst.halted", {31'd0, halted}, 32'd0);
        check_eq("rst.imem_addr", imem_addr, 32'd0);
        step();
        rst_n = 1'b1;

        // Straight-line run through all of memory with decode always ready.
        en = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            check_head($sformatf("seq%0d", i), 32'(i));
        end
        step();
        check_empty("end", 32'd32);
        check_eq("end.halted", {31'd0, halted}, 32'd1);

        // Redirect beyond memory halts; redirect back into memory resumes.
        redirect_valid = 1'b1; redirect_pc = 32'd40;
        step();
        redirect_valid = 1'b0;
        check_empty("rd40", 32'd40);
        check_eq("rd40.halted", {31'd0, halted}, 32'd1);
        step();
        check_eq("rd40.hold", {31'd0, halted}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'd5;
        step();
        redirect_valid = 1'b0;
        check_empty("rd5", 32'd5);
        check_eq("rd5.halted", {31'd0, halted}, 32'd0);
        step();
        check_head("rd5.first", 32'd5);
        step();
        check_head("rd5.next", 32'd6);

        // Backpressure: buffer fills with 0,1 and holds.
        rst_n = 1'b0; en = 1'b0; instr_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_head($sformatf("stall%0d", i), 32'd0);
        end
        check_eq("stall.imem_addr", imem_addr, 32'd2);
        instr_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_head($sformatf("drain%0d", i), 32'(i));
        end
        // Buffer now holds 3,4; redirect must drop both.
        instr_ready = 1'b0;
        check_eq("pre_rd.imem_addr", imem_addr, 32'd5);
        redirect_valid = 1'b1; redirect_pc = 32'd20; instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        check_empty("rd20", 32'd20);
        step();
        check_head("rd20.first", 32'd20);
        step();
        check_head("rd20.next", 32'd21);

        // Pause with a full buffer: pc freezes while the buffer drains.
        instr_ready = 1'b0;
        step();
        check_head("fill", 32'd21);
        check_eq("fill.imem_addr", imem_addr, 32'd23);
        en = 1'b0; instr_ready = 1'b1;
        step();
        check_head("pause0", 32'd22);
        check_eq("pause0.imem_addr", imem_addr, 32'd23);
        step();
        check_empty("pause1", 32'd23);
        step();
        check_empty("pause2", 32'd23);
        en = 1'b1;
        step();
        check_head("resume0", 32'd23);
        step();
        check_head("resume1", 32'd24);

        // Asynchronous reset with a full buffer.
        instr_ready = 1'b0;
        step();
        check_eq("prerst.imem_addr", imem_addr, 32'd26);
        rst_n = 1'b0; en = 1'b0;
        #1;
        check_eq("arst.valid", {31'd0, instr_valid}, 32'd0);
        check_eq("arst.imem_addr", imem_addr, 32'd0);
        check_eq("arst.instr", instr, 32'd0);
        check_eq("arst.instr_pc", instr_pc, 32'd0);
        check_eq("arst.halted", {31'd0, halted}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check_empty("post_rst", 32'd0);
        en = 1'b1; instr_ready = 1'b1;
        step();
        check_head("restart0", 32'd0);
        step();
        check_head("restart1", 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
